// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the Y86 fetch stage: bus widths, instruction codes,
// status codes, the fetch FSM state type and a byte-lane helper for the
// big-endian 6-byte instruction window returned by the ROM.
package inst_fetch_pkg;

  localparam int WORD_W    = 32;
  localparam int INSTBUS_W = 48;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // Byte idx of the window; byte 0 (the byte at pc) sits in the top lane.
  function automatic logic [7:0] inst_byte(input logic [INSTBUS_W-1:0] win,
                                           input int unsigned idx);
    return win[(INSTBUS_W-1)-8*idx -: 8];
  endfunction

endpackage

// File: rtl/inst_fetch_ilen_decode.sv
// y86_ilen_decode: combinational length/format lookup for one Y86 icode.
// Ports:
//   icode       in  4  instruction code (byte0[7:4])
//   len         out 3  instruction length in bytes (1 for invalid codes)
//   need_regids out 1  byte 1 carries rA/rB
//   need_valc   out 1  instruction carries a 32-bit constant
//   valc_off    out 2  byte offset of the constant inside the window
//   invalid     out 1  icode is not a Y86 instruction
module y86_ilen_decode
  import inst_fetch_pkg::*;
(
  input  logic [3:0] icode,
  output logic [2:0] len,
  output logic       need_regids,
  output logic       need_valc,
  output logic [1:0] valc_off,
  output logic       invalid
);

  always_comb begin
    len         = 3'd1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    valc_off    = 2'd0;
    invalid     = 1'b0;
    case (icode)
      IHALT, INOP, IRET: ;
      IRRMOVL, IOPL, IPUSHL, IPOPL: begin
        len         = 3'd2;
        need_regids = 1'b1;
      end
      IJXX, ICALL: begin
        len       = 3'd5;
        need_valc = 1'b1;
        valc_off  = 2'd1;
      end
      IIRMOVL, IRMMOVL, IMRMOVL: begin
        len         = 3'd6;
        need_regids = 1'b1;
        need_valc   = 1'b1;
        valc_off    = 2'd2;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: Y86 fetch stage. Owns the PC, presents it as the ROM byte
// address, splits the returned window into instruction fields and hands one
// instruction per transfer to decode over a valid/ready handshake.
// Ports:
//   clk, rst                       clock, async active-high reset
//   rom_addr_o  / rom_inst_i       ROM byte address (= pc_q) / 6-byte window
//   redirect_i  / redirect_pc_i    load a new PC, flush the held instruction
//   id_ready_i                     decode accepts this cycle
//   id_valid_o, id_pc_o, id_icode_o, id_ifun_o, id_ra_o, id_rb_o,
//   id_valc_o, id_valp_o, id_stat_o  held instruction for decode
//   halted_o                       fetch stopped after a non-AOK instruction
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0,
  parameter int unsigned       IMEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_W-1:0]    rom_addr_o,
  input  logic [INSTBUS_W-1:0] rom_inst_i,
  input  logic                 redirect_i,
  input  logic [WORD_W-1:0]    redirect_pc_i,
  input  logic                 id_ready_i,
  output logic                 id_valid_o,
  output logic [WORD_W-1:0]    id_pc_o,
  output logic [3:0]           id_icode_o,
  output logic [3:0]           id_ifun_o,
  output logic [3:0]           id_ra_o,
  output logic [3:0]           id_rb_o,
  output logic [WORD_W-1:0]    id_valc_o,
  output logic [WORD_W-1:0]    id_valp_o,
  output logic [2:0]           id_stat_o,
  output logic                 halted_o
);

  localparam logic [WORD_W:0] IMEM_END = (WORD_W+1)'(IMEM_BYTES);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q;
  logic              vld_p1;

  logic [7:0]        b0_p0, b1_p0, b2_p0, b3_p0, b4_p0, b5_p0;
  logic [2:0]        len_p0;
  logic              regids_p0, need_valc_p0, invalid_p0;
  logic [1:0]        valc_off_p0;
  logic [WORD_W:0]   end_p0;
  logic              adr_p0;
  logic [3:0]        ra_p0, rb_p0;
  logic [WORD_W-1:0] valc_p0;
  logic [2:0]        stat_p0;
  logic              load, drain;

  logic [WORD_W-1:0] pc_p1, valc_p1, valp_p1;
  logic [3:0]        icode_p1, ifun_p1, ra_p1, rb_p1;
  logic [2:0]        stat_p1;

  // ---- p0: combinational decode of the window at pc_q ----
  assign rom_addr_o = pc_q;

  assign b0_p0 = inst_byte(rom_inst_i, 0);
  assign b1_p0 = inst_byte(rom_inst_i, 1);
  assign b2_p0 = inst_byte(rom_inst_i, 2);
  assign b3_p0 = inst_byte(rom_inst_i, 3);
  assign b4_p0 = inst_byte(rom_inst_i, 4);
  assign b5_p0 = inst_byte(rom_inst_i, 5);

  y86_ilen_decode u_ilen (
    .icode       (b0_p0[7:4]),
    .len         (len_p0),
    .need_regids (regids_p0),
    .need_valc   (need_valc_p0),
    .valc_off    (valc_off_p0),
    .invalid     (invalid_p0)
  );

  // One extra bit catches a 32-bit wrap as well as running off the ROM end.
  assign end_p0 = {1'b0, pc_q} + {{(WORD_W-2){1'b0}}, len_p0};
  assign adr_p0 = end_p0 > IMEM_END;

  assign ra_p0 = regids_p0 ? b1_p0[7:4] : REG_NONE;
  assign rb_p0 = regids_p0 ? b1_p0[3:0] : REG_NONE;

  // Constant is little-endian in memory while the window is big-endian.
  always_comb begin
    valc_p0 = '0;
    if (need_valc_p0) begin
      if (valc_off_p0 == 2'd1) valc_p0 = {b4_p0, b3_p0, b2_p0, b1_p0};
      else                     valc_p0 = {b5_p0, b4_p0, b3_p0, b2_p0};
    end
  end

  always_comb begin
    if (adr_p0)                  stat_p0 = SADR;
    else if (invalid_p0)         stat_p0 = SINS;
    else if (b0_p0[7:4] == IHALT) stat_p0 = SHLT;
    else                         stat_p0 = SAOK;
  end

  // Redirect overrides any load or drain in the same cycle.
  assign load  = (state_q == ST_RUN) && (!vld_p1 || id_ready_i) && !redirect_i;
  assign drain = (state_q == ST_HALTED) && vld_p1 && id_ready_i && !redirect_i;

  always_comb begin
    state_d = state_q;
    if (redirect_i)                   state_d = ST_RUN;
    else if (load && stat_p0 != SAOK) state_d = ST_HALTED;
  end

  // ---- p1: state register, PC and decode-stage output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // A faulting/halting instruction leaves the PC pointing at itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      vld_p1 <= 1'b0;
    end else if (redirect_i) begin
      pc_q   <= redirect_pc_i;
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      if (stat_p0 == SAOK) pc_q <= end_p0[WORD_W-1:0];
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p1    <= '0;
      icode_p1 <= '0;
      ifun_p1  <= '0;
      ra_p1    <= '0;
      rb_p1    <= '0;
      valc_p1  <= '0;
      valp_p1  <= '0;
      stat_p1  <= '0;
    end else if (load) begin
      pc_p1    <= pc_q;
      icode_p1 <= b0_p0[7:4];
      ifun_p1  <= b0_p0[3:0];
      ra_p1    <= ra_p0;
      rb_p1    <= rb_p0;
      valc_p1  <= valc_p0;
      valp_p1  <= end_p0[WORD_W-1:0];
      stat_p1  <= stat_p0;
    end
  end

  assign id_valid_o = vld_p1;
  assign id_pc_o    = pc_p1;
  assign id_icode_o = icode_p1;
  assign id_ifun_o  = ifun_p1;
  assign id_ra_o    = ra_p1;
  assign id_rb_o    = rb_p1;
  assign id_valc_o  = valc_p1;
  assign id_valp_o  = valp_p1;
  assign id_stat_o  = stat_p1;
  assign halted_o   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: byte-array ROM, directed scenarios, then random
// streams with redirects, compared against an instruction-level model.
module tb_inst_fetch;

  localparam int IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [47:0] rom_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc, id_valc, id_valp;
  logic [3:0]  id_icode, id_ifun, id_ra, id_rb;
  logic [2:0]  id_stat;
  logic        halted;

  logic [7:0]   mem [0:IMEM-1];
  logic [31:0]  win_a;
  logic [114:0] outs;

  int checks = 0;
  int errors = 0;

  logic [114:0] m_inst;
  logic [31:0]  m_pc;
  bit           m_valid, m_halted;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr_o    (rom_addr),
    .rom_inst_i    (rom_inst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .id_pc_o       (id_pc),
    .id_icode_o    (id_icode),
    .id_ifun_o     (id_ifun),
    .id_ra_o       (id_ra),
    .id_rb_o       (id_rb),
    .id_valc_o     (id_valc),
    .id_valp_o     (id_valp),
    .id_stat_o     (id_stat),
    .halted_o      (halted)
  );

  // ROM: bytes beyond the array read as zero.
  always_comb begin
    rom_inst = '0;
    win_a    = '0;
    for (int i = 0; i < 6; i++) begin
      win_a = rom_addr + 32'(i);
      rom_inst[47-8*i -: 8] = (win_a < 32'(IMEM)) ? mem[win_a[9:0]] : 8'h00;
    end
  end

  assign outs = {id_pc, id_icode, id_ifun, id_ra, id_rb, id_valc, id_valp, id_stat};

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (a < 32'(IMEM)) return mem[a[9:0]];
    return 8'h00;
  endfunction

  // Expected instruction record for the instruction starting at pc:
  // {pc, icode, ifun, ra, rb, valc, valp, stat}.
  function automatic logic [114:0] exp_inst(input logic [31:0] pc);
    logic [7:0]  b [0:5];
    int          len, voff;
    bit          regs, bad;
    logic [3:0]  ra, rb;
    logic [31:0] valc, valp;
    logic [2:0]  st;
    logic [63:0] fin;
    for (int i = 0; i < 6; i++) b[i] = mb(pc + 32'(i));
    regs = 0; voff = -1; bad = 0; len = 1;
    case (b[0][7:4])
      4'h0, 4'h1, 4'h9:       len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 2; regs = 1; end
      4'h7, 4'h8:             begin len = 5; voff = 1; end
      4'h3, 4'h4, 4'h5:       begin len = 6; regs = 1; voff = 2; end
      default:                begin len = 1; bad = 1; end
    endcase
    ra = regs ? b[1][7:4] : 4'hF;
    rb = regs ? b[1][3:0] : 4'hF;
    valc = 32'h0;
    if (voff > 0) valc = {b[voff+3], b[voff+2], b[voff+1], b[voff]};
    valp = pc + 32'(len);
    fin  = {32'h0, pc} + 64'(len);
    if (fin > 64'(IMEM))      st = 3'd3;
    else if (bad)             st = 3'd4;
    else if (b[0][7:4] == 0)  st = 3'd2;
    else                      st = 3'd1;
    return {pc, b[0][7:4], b[0][3:0], ra, rb, valc, valp, st};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_halted = 0;
  endtask

  // Drive one cycle of inputs, advance the model by one transfer, compare.
  task automatic step(input bit ready, input bit redir, input logic [31:0] rpc);
    id_ready = ready; redirect = redir; redirect_pc = rpc;
    if (redir) begin
      m_pc = rpc; m_valid = 0; m_halted = 0;
    end else if (!m_halted && (!m_valid || ready)) begin
      m_inst  = exp_inst(m_pc);
      m_valid = 1;
      if (m_inst[2:0] != 3'd1) m_halted = 1;
      else                     m_pc = m_inst[34:3];
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
    check("valid", id_valid, m_valid);
    check("rom_addr", rom_addr, m_pc);
    check("halted", halted, m_halted);
    if (m_valid) check("inst", outs, m_inst);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < IMEM; a++) mem[a] = 8'h00;
    rst = 1'b1; redirect = 0; redirect_pc = 0; id_ready = 0;
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h78;
    mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    check("rst_valid", id_valid, 1'b0);
    check("rst_data", outs, 115'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", rom_addr, 32'h0);

    // irmovl $0x12345678, %ebx
    step(1, 0, 0);
    check("irmovl_icode", id_icode, 4'h3);
    check("irmovl_ra", id_ra, 4'hF);
    check("irmovl_rb", id_rb, 4'h3);
    check("irmovl_valc", id_valc, 32'h12345678);
    check("irmovl_valp", id_valp, 32'd6);
    check("irmovl_stat", id_stat, 3'd1);
    check("irmovl_next_pc", rom_addr, 32'd6);

    // nop ; addl ; halt
    mem[16] = 8'h10; mem[17] = 8'h60; mem[18] = 8'h12; mem[19] = 8'h00;
    step(1, 1, 32'h10);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("halt_stat", id_stat, 3'd2);
    check("halt_halted", halted, 1'b1);
    check("halt_addr", rom_addr, 32'h13);
    step(1, 0, 0);
    step(1, 0, 0);

    // rrmovl ; jmp ; ret with a 4-cycle stall
    mem[32] = 8'h20; mem[33] = 8'h12; mem[34] = 8'h70; mem[35] = 8'h00;
    mem[36] = 8'h01; mem[37] = 8'h00; mem[38] = 8'h00; mem[39] = 8'h90;
    step(1, 1, 32'h20);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    step(1, 0, 0);
    check("jmp_valc", id_valc, 32'h100);
    step(1, 0, 0);

    // Redirect flushes the held instruction even with ready high.
    mem[64] = 8'h61; mem[65] = 8'h34;
    step(1, 1, 32'h40);
    step(1, 0, 0);
    check("redir_pc", id_pc, 32'h40);

    // Invalid opcode.
    mem[80] = 8'hF0;
    step(1, 1, 32'h50);
    step(1, 0, 0);
    check("ins_stat", id_stat, 3'd4);
    check("ins_valp", id_valp, 32'h51);
    check("ins_addr", rom_addr, 32'h50);

    // irmovl running off the ROM end, then restart.
    mem[1020] = 8'h30; mem[1021] = 8'hF2; mem[1022] = 8'h01; mem[1023] = 8'h02;
    step(1, 1, 32'(IMEM - 4));
    step(1, 0, 0);
    check("adr_stat", id_stat, 3'd3);
    step(1, 1, 32'h0);
    check("restart_halted", halted, 1'b0);

    // Asynchronous reset in the middle of a stall.
    step(1, 1, 32'h20);
    step(1, 0, 0);
    step(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", id_valid, 1'b0);
    check("arst_addr", rom_addr, 32'h0);
    check("arst_halted", halted, 1'b0);
    #1 rst = 1'b0;
    model_reset();

    // Random programs, random ready, random redirects.
    for (int a = 0; a < IMEM; a++) begin
      if ($urandom_range(0, 15) < 13)
        mem[a] = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))};
      else
        mem[a] = 8'($urandom_range(0, 255));
    end
    for (int n = 0; n < 400; n++) begin
      bit          r, d;
      logic [31:0] t;
      r = ($urandom_range(0, 3) != 0);
      d = m_halted ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, IMEM - 1));
      step(r, d, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
